// File: rtl/weight_ctrl_pkg.sv
// Shared definitions for the weight load controller: FSM encoding and
// the row counter width helper.
package weight_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a counter that indexes rows 0..rows-1 (never narrower than 1 bit).
   function automatic int row_cnt_w(input int rows);
      return (rows < 2) ? 1 : $clog2(rows);
   endfunction

endpackage

// File: rtl/row_sel_dec.sv
// Row select decoder: turns the current row index into a one-hot reload
// vector, all zero unless a beat is being accepted this cycle.
module row_sel_dec
   import weight_ctrl_pkg::*;
#(
   parameter int ROWS  = 8,
   parameter int CNT_W = 3
) (
   input  logic [CNT_W-1:0] row_cnt,
   input  logic             accept,
   output logic [ROWS-1:0]  row_sel
);

   // Compare against every row index so no out-of-range bit can be set.
   always_comb begin
      row_sel = '0;
      for (int r = 0; r < ROWS; r++) begin
         row_sel[r] = accept && (row_cnt == CNT_W'(r));
      end
   end

endmodule

// File: rtl/weight_load_ctrl.sv
// Weight load controller: accepts one row of weights per stream beat and
// drives the shared row bus plus a one-hot per-row reload strobe.
//
// Handshake: a beat transfers on a rising edge where s_valid && s_ready and
// abort is low. s_ready depends only on the FSM state (high in LOAD), never
// on s_valid; the source must hold s_data stable while s_valid is high and
// the beat has not yet transferred.
module weight_load_ctrl
   import weight_ctrl_pkg::*;
#(
   parameter int WEIGHT_BW = 8,
   parameter int ROWS      = 8,
   parameter int COLS      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [COLS*WEIGHT_BW-1:0] s_data,
   output logic [COLS*WEIGHT_BW-1:0] row_data,
   output logic [ROWS-1:0]           row_reload,
   output logic                      busy,
   output logic                      done,
   output logic                      weights_valid
);

   localparam int ROW_CNT_W = row_cnt_w(ROWS);

   state_t                 state;
   state_t                 state_nxt;
   logic [ROW_CNT_W-1:0]   row_cnt;
   logic                   accept;
   logic                   last_row;
   logic [ROWS-1:0]        reload_sel;

   assign s_ready  = (state == LOAD);
   // Abort wins over a beat presented in the same cycle.
   assign accept   = s_valid && s_ready && !abort;
   assign last_row = (row_cnt == ROW_CNT_W'(ROWS - 1));
   assign busy     = (state != IDLE);
   // done lines up with the registered reload pulse of the final row.
   assign done     = (state == DONE);

   row_sel_dec #(
      .ROWS  (ROWS),
      .CNT_W (ROW_CNT_W)
   ) u_row_sel_dec (
      .row_cnt (row_cnt),
      .accept  (accept),
      .row_sel (reload_sel)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: start only matters in IDLE, abort only in LOAD.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = LOAD;
         LOAD: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (accept && last_row) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Row counter, row bus, reload strobe and matrix-valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt       <= '0;
         row_data      <= '0;
         row_reload    <= '0;
         weights_valid <= 1'b0;
      end else begin
         row_reload <= reload_sel;
         if (accept) begin
            row_data <= s_data;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  row_cnt       <= '0;
                  weights_valid <= 1'b0;
               end
            end
            LOAD: begin
               if (abort) begin
                  row_cnt <= '0;
               end else if (accept) begin
                  if (last_row) begin
                     row_cnt       <= '0;
                     weights_valid <= 1'b1;
                  end else begin
                     row_cnt <= row_cnt + ROW_CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: directed scenarios plus a randomized phase,
// checked each cycle against a row-transfer model of the load protocol.
module tb_weight_load_ctrl;

   localparam int WEIGHT_BW = 8;
   localparam int ROWS      = 8;
   localparam int COLS      = 8;
   localparam int DW        = COLS * WEIGHT_BW;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            abort;
   logic            s_valid;
   logic            s_ready;
   logic [DW-1:0]   s_data;
   logic [DW-1:0]   row_data;
   logic [ROWS-1:0] row_reload;
   logic            busy;
   logic            done;
   logic            weights_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // model of the load protocol
   bit              m_load;
   bit              m_fin;
   bit              m_wv;
   int              m_rows;
   logic [ROWS-1:0] exp_reload;
   logic [DW-1:0]   exp_data;
   logic [DW-1:0]   exp_q[$];
   logic [DW-1:0]   arr[ROWS];

   weight_load_ctrl #(
      .WEIGHT_BW (WEIGHT_BW),
      .ROWS      (ROWS),
      .COLS      (COLS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .row_data      (row_data),
      .row_reload    (row_reload),
      .busy          (busy),
      .done          (done),
      .weights_valid (weights_valid)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic st, input logic ab, input logic v, input logic [DW-1:0] d);
      start   = st;
      abort   = ab;
      s_valid = v;
      s_data  = d;
   endtask

   // Advance the model by one edge using the inputs currently applied.
   task automatic model_step();
      if (rst) begin
         m_load = 0; m_fin = 0; m_wv = 0; m_rows = 0;
         exp_reload = '0; exp_data = '0;
         exp_q.delete();
      end else if (m_fin) begin
         m_fin = 0;
         exp_reload = '0;
      end else if (m_load) begin
         if (abort) begin
            m_load = 0; m_rows = 0;
            exp_reload = '0;
            exp_q.delete();
         end else if (s_valid) begin
            exp_reload = ROWS'(1) << m_rows;
            exp_data   = s_data;
            exp_q.push_back(s_data);
            m_rows++;
            if (m_rows == ROWS) begin
               m_rows = 0; m_load = 0; m_fin = 1; m_wv = 1;
            end
         end else begin
            exp_reload = '0;
         end
      end else begin
         exp_reload = '0;
         if (start) begin
            m_load = 1; m_rows = 0; m_wv = 0;
            exp_q.delete();
         end
      end
   endtask

   task automatic check_outputs();
      chk("s_ready", s_ready, m_load);
      chk("busy", busy, m_load || m_fin);
      chk("done", done, m_fin);
      chk("weights_valid", weights_valid, m_wv);
      chk("row_reload", row_reload, exp_reload);
      chk("row_data", row_data, exp_data);
      chk("reload_onehot0", $countones(row_reload) <= 1, 1'b1);
      // emulate the weight registers capturing the row bus
      for (int r = 0; r < ROWS; r++) begin
         if (row_reload[r]) arr[r] = row_data;
      end
      if (m_fin) begin
         chk("matrix_rows", exp_q.size(), ROWS);
         for (int r = 0; r < ROWS; r++) begin
            chk($sformatf("matrix_row%0d", r), arr[r], exp_q[r]);
         end
         exp_q.delete();
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [DW-1:0] row_pat(input int r);
      logic [7:0] b;
      b = 8'(r + 1);
      return {COLS{b}};
   endfunction

   initial begin
      m_load = 0; m_fin = 0; m_wv = 0; m_rows = 0;
      exp_reload = '0; exp_data = '0;
      for (int r = 0; r < ROWS; r++) arr[r] = '0;

      // 1: reset with start and s_valid active
      rst = 1'b1;
      set_in(1'b1, 1'b0, 1'b1, rnd_data());
      cycle();
      cycle();
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, '0);
      cycle();

      // 2: full load, back-to-back beats with row-index pattern
      set_in(1'b1, 1'b0, 1'b0, '0);
      cycle();
      for (int r = 0; r < ROWS; r++) begin
         set_in(1'b0, 1'b0, 1'b1, row_pat(r));
         cycle();
      end
      set_in(1'b0, 1'b0, 1'b0, rnd_data());
      cycle();
      cycle();

      // 3: stalls, s_valid toggling
      set_in(1'b1, 1'b0, 1'b0, '0);
      cycle();
      for (int i = 0; i < 2 * ROWS; i++) begin
         set_in(1'b0, 1'b0, (i % 2) == 0, rnd_data());
         cycle();
      end
      set_in(1'b0, 1'b0, 1'b0, '0);
      cycle();
      cycle();

      // 4: abort after 3 rows with a beat offered, then restart from row 0
      set_in(1'b1, 1'b0, 1'b0, '0);
      cycle();
      for (int r = 0; r < 3; r++) begin
         set_in(1'b0, 1'b0, 1'b1, rnd_data());
         cycle();
      end
      set_in(1'b0, 1'b1, 1'b1, rnd_data());
      cycle();
      set_in(1'b0, 1'b0, 1'b1, rnd_data());
      cycle();
      set_in(1'b1, 1'b0, 1'b0, '0);
      cycle();
      for (int r = 0; r < ROWS; r++) begin
         set_in(1'b0, 1'b0, 1'b1, rnd_data());
         cycle();
      end
      set_in(1'b0, 1'b0, 1'b0, '0);
      cycle();

      // 5: start held through load and the done cycle, then a new load
      set_in(1'b1, 1'b0, 1'b0, '0);
      cycle();
      for (int r = 0; r < ROWS + 1; r++) begin
         set_in(1'b1, 1'b0, 1'b1, rnd_data());
         cycle();
      end
      set_in(1'b1, 1'b0, 1'b0, '0);
      cycle();
      for (int r = 0; r < ROWS; r++) begin
         set_in(1'b0, 1'b0, 1'b1, rnd_data());
         cycle();
      end
      set_in(1'b0, 1'b0, 1'b0, '0);
      cycle();

      // 6: reset in the middle of a load, then restart
      set_in(1'b1, 1'b0, 1'b0, '0);
      cycle();
      for (int r = 0; r < 5; r++) begin
         set_in(1'b0, 1'b0, 1'b1, rnd_data());
         cycle();
      end
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b1, rnd_data());
      cycle();
      rst = 1'b0;
      set_in(1'b1, 1'b0, 1'b0, '0);
      cycle();
      set_in(1'b0, 1'b0, 1'b1, rnd_data());
      cycle();
      set_in(1'b0, 1'b0, 1'b0, '0);
      cycle();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         set_in($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 2) != 0, rnd_data());
         cycle();
      end
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, '0);
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
